data_bus_arbiter: RTL and testbench

//  Shares the single-port data RAM (8-bit, 1-cycle registered read) between avr_cpu

---
 rtl/data_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_data_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - data RAM arbiter between the CPU data port and a DMA/debug master
// CPU has default priority; a starvation counter and a capped locked-burst mode keep DMA moving.
module data_bus_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_ren,
    input  logic              cpu_wen,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    typedef enum logic [1:0] {
        ARB,
        BURST,
        YIELD
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic               cpu_act;
    logic               dma_arb;
    logic               dma_win;
    logic               cpu_win;

    assign cpu_act = cpu_ren | cpu_wen;
    // Plain arbitration outcome, shared by ARB and the early-exit path out of BURST.
    assign dma_arb = dma_req & (~cpu_act | (wait_cnt >= WAIT_MAX));

    always_comb begin
        next_state = state;
        dma_win    = 1'b0;
        case (state)
            ARB: begin
                dma_win = dma_arb;
                if (dma_arb && dma_lock) begin
                    next_state = BURST;
                end
            end
            BURST: begin
                if (!(dma_req && dma_lock)) begin
                    dma_win    = dma_arb;
                    next_state = ARB;
                end else if (burst_cnt < BURST_MAX) begin
                    dma_win = 1'b1;
                end else begin
                    next_state = YIELD;
                end
            end
            YIELD: begin
                dma_win    = dma_req & ~cpu_act;
                next_state = ARB;
            end
            default: next_state = ARB;
        endcase
        if (!reset) begin
            dma_win = 1'b0;
        end
    end

    assign cpu_win   = reset & cpu_act & ~dma_win;
    assign dma_gnt   = dma_win;
    assign cpu_stall = cpu_act & dma_win;
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        if (dma_win) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_ren   = ~dma_we;
            mem_wen   = dma_we;
        end else if (cpu_win) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_ren   = cpu_ren;
            mem_wen   = cpu_wen;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB;
        end else begin
            state <= next_state;
        end
    end

    // A locked grant outside YIELD either opens a burst (from ARB) or extends it (in BURST).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt <= '0;
        end else if (dma_win && dma_lock && state != YIELD) begin
            burst_cnt <= (state == BURST) ? burst_cnt + 1'b1 : BURST_W'(1);
        end else if (next_state != BURST) begin
            burst_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!dma_req || dma_win) begin
            wait_cnt <= '0;
        end else if (wait_cnt < WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dma_rvalid <= 1'b0;
        end else begin
            dma_rvalid <= dma_win & ~dma_we;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - self-checking bench for data_bus_arbiter
// Directed scenarios plus randomized traffic against a rule-level reference model.
module tb_data_bus_arbiter;

    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_ren;
    logic        cpu_wen;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic        dma_lock;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    data_bus_arbiter #(
        .ADDR_W(16), .DATA_W(8), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_ren(cpu_ren), .cpu_wen(cpu_wen),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with 1-cycle registered read (low 8 address bits only)
    bit [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr[7:0]] <= mem_wdata;
        if (mem_ren) mem_rdata <= ram[mem_addr[7:0]];
    end

    // Reference model: streak of denials, length of current locked burst, pending yield
    bit [7:0] sh [256];
    int  m_denied = 0, m_burst = 0;
    bit  m_yield = 1'b0;
    int  n_denied, n_burst;
    bit  n_yield;
    bit  e_gnt, e_stall, e_ren, e_wen, e_cpu_win;
    bit  e_rv = 1'b0, e_crv = 1'b0;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata, e_rv_data, e_crv_data;

    task automatic eval_model();
        bit act;
        act = cpu_ren | cpu_wen;
        e_gnt = 1'b0; n_yield = 1'b0; n_burst = 0;
        if (!reset) begin
            e_rv = 1'b0; e_crv = 1'b0; n_denied = 0;
        end else if (m_yield) begin
            e_gnt = dma_req && !act;
        end else if (m_burst > 0 && dma_req && dma_lock) begin
            if (m_burst < MAX_BURST) begin
                e_gnt = 1'b1; n_burst = m_burst + 1;
            end else begin
                n_yield = 1'b1;
            end
        end else begin
            e_gnt = dma_req && (!act || m_denied >= MAX_WAIT);
            n_burst = (e_gnt && dma_lock) ? 1 : 0;
        end
        if (reset) n_denied = (dma_req && !e_gnt) ? ((m_denied + 1 > MAX_WAIT) ? MAX_WAIT : m_denied + 1) : 0;
        e_cpu_win = reset && act && !e_gnt;
        e_stall = act && e_gnt;
        e_ren = e_gnt ? !dma_we : (e_cpu_win && cpu_ren);
        e_wen = e_gnt ? dma_we : (e_cpu_win && cpu_wen);
        e_addr = e_gnt ? dma_addr : (e_cpu_win ? cpu_addr : 16'h0);
        e_wdata = e_gnt ? dma_wdata : (e_cpu_win ? cpu_wdata : 8'h0);
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset) begin
            m_denied = 0; m_burst = 0; m_yield = 1'b0; e_rv = 1'b0; e_crv = 1'b0;
        end else begin
            m_denied = n_denied; m_burst = n_burst; m_yield = n_yield;
            e_rv = e_gnt && !dma_we;
            e_rv_data = sh[dma_addr[7:0]];
            e_crv = e_cpu_win && cpu_ren;
            e_crv_data = sh[cpu_addr[7:0]];
            if (e_gnt && dma_we) sh[dma_addr[7:0]] = dma_wdata;
            if (e_cpu_win && cpu_wen) sh[cpu_addr[7:0]] = cpu_wdata;
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        cpu_addr = '0; cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic test_reset();
        cpu_ren = 1'b1; dma_req = 1'b1; dma_lock = 1'b1;
        #1;
        eval_model();
        total_cnt++;
        if ({dma_gnt, cpu_stall, mem_ren, mem_wen, dma_rvalid} !== 5'b0)
            $display("FAIL reset_outputs: got %b want 00000", {dma_gnt, cpu_stall, mem_ren, mem_wen, dma_rvalid});
        else pass_cnt++;
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        #1;
        eval_model();
        advance();
    endtask

    task automatic test_cpu_only();
        cpu_wen = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h5A;
        #1; eval_model();
        total_cnt++;
        if ({mem_wen, mem_ren, cpu_stall, mem_addr, mem_wdata} !== {3'b100, 16'h0010, 8'h5A})
            $display("FAIL cpu_write: got %b%b%b %h %h want 100 0010 5a", mem_wen, mem_ren, cpu_stall, mem_addr, mem_wdata);
        else pass_cnt++;
        advance();
        cpu_wen = 1'b0; cpu_ren = 1'b1;
        #1; eval_model();
        total_cnt++;
        if ({mem_ren, mem_wen, cpu_stall, mem_addr} !== {3'b100, 16'h0010})
            $display("FAIL cpu_read: got %b%b%b %h want 100 0010", mem_ren, mem_wen, cpu_stall, mem_addr);
        else pass_cnt++;
        advance();
        set_idle();
        #1; eval_model();
        total_cnt++;
        if ({cpu_rdata, mem_wen, cpu_stall} !== {8'h5A, 2'b00})
            $display("FAIL cpu_rdata: got %h %b%b want 5a 00", cpu_rdata, mem_wen, cpu_stall);
        else pass_cnt++;
        advance();
    endtask

    task automatic test_dma_only();
        cpu_wen = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'hC3;
        #1; eval_model(); advance();
        set_idle();
        dma_req = 1'b1; dma_addr = 16'h0020;
        #1; eval_model();
        total_cnt++;
        if ({dma_gnt, mem_ren, mem_wen, cpu_stall, mem_addr} !== {4'b1100, 16'h0020})
            $display("FAIL dma_grant: got %b%b%b%b %h want 1100 0020", dma_gnt, mem_ren, mem_wen, cpu_stall, mem_addr);
        else pass_cnt++;
        advance();
        dma_req = 1'b0;
        #1; eval_model();
        total_cnt++;
        if ({dma_rvalid, dma_rdata} !== {1'b1, 8'hC3})
            $display("FAIL dma_rvalid: got %b %h want 1 c3", dma_rvalid, dma_rdata);
        else pass_cnt++;
        advance();
        #1; eval_model();
        total_cnt++;
        if (dma_rvalid !== 1'b0) $display("FAIL dma_rvalid_pulse: got %b want 0", dma_rvalid);
        else pass_cnt++;
        advance();
    endtask

    // CPU hammers reads while DMA waits; shared by starvation and post-reset scenarios
    task automatic test_starvation(input string tag);
        int gnt_at = 0, stall_n = 0;
        cpu_ren = 1'b1; cpu_addr = 16'h0030;
        dma_req = 1'b1; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = 16'h0020;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            #1; eval_model();
            total_cnt++;
            if ({dma_gnt, cpu_stall, mem_ren, mem_wen, dma_rvalid} !== {e_gnt, e_stall, e_ren, e_wen, e_rv})
                $display("FAIL %s_ctrl cyc %0d: got %b want %b", tag, cyc,
                         {dma_gnt, cpu_stall, mem_ren, mem_wen, dma_rvalid}, {e_gnt, e_stall, e_ren, e_wen, e_rv});
            else pass_cnt++;
            if (dma_gnt && gnt_at == 0) gnt_at = cyc;
            if (cpu_stall) stall_n++;
            advance();
            if (gnt_at != 0) dma_req = 1'b0;
        end
        total_cnt++;
        if (gnt_at != MAX_WAIT + 1 || stall_n != 1)
            $display("FAIL %s_grant_cycle: got grant cycle %0d stalls %0d want %0d and 1", tag, gnt_at, stall_n, MAX_WAIT + 1);
        else pass_cnt++;
        set_idle();
    endtask

    task automatic test_burst_cap();
        logic [17:0] seq = '0;
        cpu_ren = 1'b1; cpu_addr = 16'h0031;
        dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            dma_addr = 16'($urandom_range(64, 95)); dma_wdata = 8'($urandom);
            #1; eval_model();
            total_cnt++;
            if ({dma_gnt, cpu_stall, mem_ren, mem_wen} !== {e_gnt, e_stall, e_ren, e_wen})
                $display("FAIL burst_cap_ctrl cyc %0d: got %b want %b", cyc,
                         {dma_gnt, cpu_stall, mem_ren, mem_wen}, {e_gnt, e_stall, e_ren, e_wen});
            else pass_cnt++;
            seq = {seq[16:0], dma_gnt};
            advance();
        end
        total_cnt++;
        if (seq !== 18'b0000_11111111_0000_11)
            $display("FAIL burst_cap_pattern: got %b want 000011111111000011", seq);
        else pass_cnt++;
        set_idle();
        #1; eval_model(); advance();
    endtask

    task automatic test_burst_early_exit();
        int grants = 0;
        dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1; dma_addr = 16'h0050; dma_wdata = 8'h11;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            #1; eval_model();
            if (dma_gnt) grants++;
            advance();
        end
        total_cnt++;
        if (grants != 3) $display("FAIL early_exit_grants: got %0d want 3", grants);
        else pass_cnt++;
        dma_lock = 1'b0; cpu_ren = 1'b1; cpu_addr = 16'h0050;
        #1; eval_model();
        total_cnt++;
        if ({dma_gnt, cpu_stall, mem_ren, mem_addr} !== {3'b001, 16'h0050})
            $display("FAIL early_exit_cpu: got %b%b%b %h want 001 0050", dma_gnt, cpu_stall, mem_ren, mem_addr);
        else pass_cnt++;
        advance();
        dma_lock = 1'b1;
        #1; eval_model();
        total_cnt++;
        if ({dma_gnt, cpu_stall, mem_ren} !== {e_gnt, e_stall, e_ren} || dma_gnt !== 1'b0)
            $display("FAIL early_exit_arb: got %b%b%b want 001", dma_gnt, cpu_stall, mem_ren);
        else pass_cnt++;
        advance();
        set_idle();
        #1; eval_model(); advance();
    endtask

    task automatic test_reset_mid_burst();
        dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b0; dma_addr = 16'h0020;
        #1; eval_model();
        total_cnt++;
        if ({dma_gnt, mem_ren} !== 2'b11) $display("FAIL rst_burst_grant: got %b%b want 11", dma_gnt, mem_ren);
        else pass_cnt++;
        #1 reset = 1'b0;
        #1; eval_model();
        total_cnt++;
        if ({dma_gnt, mem_ren, mem_wen, cpu_stall} !== 4'b0)
            $display("FAIL rst_drop: got %b%b%b%b want 0000", dma_gnt, mem_ren, mem_wen, cpu_stall);
        else pass_cnt++;
        advance();
        set_idle();
        reset = 1'b1;
        #1;
        total_cnt++;
        if (dma_rvalid !== 1'b0) $display("FAIL rst_no_rvalid: got %b want 0", dma_rvalid);
        else pass_cnt++;
        test_starvation("post_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (!((cpu_ren || cpu_wen) && !e_cpu_win)) begin
                int op = int'($urandom_range(0, 3));
                cpu_ren = (op == 1); cpu_wen = (op == 2);
                cpu_addr = 16'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
            end
            if (!(dma_req && !e_gnt)) begin
                bit hot = ((i / 100) % 2) == 1;
                dma_req = hot ? 1'b1 : ($urandom_range(0, 2) != 0);
                dma_lock = hot ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 1) == 1);
                dma_we = $urandom_range(0, 1) == 1;
                dma_addr = 16'($urandom_range(0, 15)); dma_wdata = 8'($urandom);
            end
            #1; eval_model();
            total_cnt++;
            if ({dma_gnt, cpu_stall, mem_ren, mem_wen, dma_rvalid, mem_addr, mem_wdata} !==
                {e_gnt, e_stall, e_ren, e_wen, e_rv, e_addr, e_wdata})
                $display("FAIL random_bus cyc %0d: got %b%b%b%b%b %h %h want %b%b%b%b%b %h %h", i,
                         dma_gnt, cpu_stall, mem_ren, mem_wen, dma_rvalid, mem_addr, mem_wdata,
                         e_gnt, e_stall, e_ren, e_wen, e_rv, e_addr, e_wdata);
            else pass_cnt++;
            if (e_rv) begin
                total_cnt++;
                if (dma_rdata !== e_rv_data) $display("FAIL random_dma_rdata cyc %0d: got %h want %h", i, dma_rdata, e_rv_data);
                else pass_cnt++;
            end
            if (e_crv) begin
                total_cnt++;
                if (cpu_rdata !== e_crv_data) $display("FAIL random_cpu_rdata cyc %0d: got %h want %h", i, cpu_rdata, e_crv_data);
                else pass_cnt++;
            end
            advance();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_cpu_only();
        test_dma_only();
        test_starvation("starve");
        test_burst_cap();
        test_burst_early_exit();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
